// File: rtl/aes_cbc_pkg.sv
// Shared types and constants for the AES-128 CBC sequencer.
package aes_cbc_pkg;

  localparam int AES_BLK_W = 128;

  typedef logic [AES_BLK_W-1:0] aes_blk_t;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_IN   = 3'd1,
    ISSUE     = 3'd2,
    WAIT_CORE = 3'd3,
    EMIT      = 3'd4,
    FIN       = 3'd5
  } seq_state_e;

endpackage

// File: rtl/aes_cbc_cfg_regs.sv
// Key / IV / skip configuration registers, locked while a message is in progress.
module aes_cbc_cfg_regs
  import aes_cbc_pkg::*;
#(
  parameter int BLK_W  = AES_BLK_W,
  parameter int SKIP_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              busy,
  input  logic              key_we,
  input  logic [BLK_W-1:0]  key,
  input  logic              iv_we,
  input  logic [BLK_W-1:0]  iv,
  input  logic              skip_we,
  input  logic [SKIP_W-1:0] skip,
  output logic [BLK_W-1:0]  key_o,
  output logic [BLK_W-1:0]  iv_eff_o,
  output logic [SKIP_W-1:0] skip_eff_o,
  output logic              cfg_err_o
);

  logic [BLK_W-1:0]  key_q, key_d;
  logic [BLK_W-1:0]  iv_q, iv_d;
  logic [SKIP_W-1:0] skip_q, skip_d;
  logic              cfg_err_q, cfg_err_d;

  always_comb begin
    key_d     = key_q;
    iv_d      = iv_q;
    skip_d    = skip_q;
    cfg_err_d = busy & (key_we | iv_we | skip_we);
    if (!busy) begin
      if (key_we)  key_d  = key;
      if (iv_we)   iv_d   = iv;
      if (skip_we) skip_d = skip;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_q     <= '0;
      iv_q      <= '0;
      skip_q    <= '0;
      cfg_err_q <= 1'b0;
    end else begin
      key_q     <= key_d;
      iv_q      <= iv_d;
      skip_q    <= skip_d;
      cfg_err_q <= cfg_err_d;
    end
  end

  // Write-through so a start in the same cycle as a cfg write sees the new value.
  assign iv_eff_o   = (!busy && iv_we)   ? iv   : iv_q;
  assign skip_eff_o = (!busy && skip_we) ? skip : skip_q;
  assign key_o      = key_q;
  assign cfg_err_o  = cfg_err_q;

endmodule

// File: rtl/aes_cbc_seq_ctrl.sv
// CBC-mode sequencer around an external single-block AES-128 encrypt core.
//   state     | meaning
//   IDLE      | config writable, waiting for start
//   WAIT_IN   | in_ready high, waiting for a plaintext block
//   ISSUE     | core_req_valid high until the core accepts
//   WAIT_CORE | waiting for the ciphertext strobe
//   EMIT      | out_valid high until the sink accepts
//   FIN       | done pulse, back to IDLE
module aes_cbc_seq_ctrl
  import aes_cbc_pkg::*;
#(
  parameter int BLK_W  = AES_BLK_W,
  parameter int SKIP_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_key_we,
  input  logic [BLK_W-1:0]  cfg_key,
  input  logic              cfg_iv_we,
  input  logic [BLK_W-1:0]  cfg_iv,
  input  logic              cfg_skip_we,
  input  logic [SKIP_W-1:0] cfg_skip,
  output logic              cfg_err,
  input  logic              start,
  output logic              busy,
  output logic              done,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [BLK_W-1:0]  in_data,
  input  logic              in_last,
  output logic              core_req_valid,
  input  logic              core_req_ready,
  output logic [BLK_W-1:0]  core_key,
  output logic [BLK_W-1:0]  core_block,
  input  logic              core_rsp_valid,
  input  logic [BLK_W-1:0]  core_rsp_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [BLK_W-1:0]  out_data,
  output logic              out_last
);

  localparam logic [2:0] S_IDLE      = IDLE;
  localparam logic [2:0] S_WAIT_IN   = WAIT_IN;
  localparam logic [2:0] S_ISSUE     = ISSUE;
  localparam logic [2:0] S_WAIT_CORE = WAIT_CORE;
  localparam logic [2:0] S_EMIT      = EMIT;
  localparam logic [2:0] S_FIN       = FIN;

  logic [2:0]        state_q, state_d;
  logic [BLK_W-1:0]  chain_q, chain_d;
  logic [SKIP_W-1:0] skip_cnt_q, skip_cnt_d;
  logic [BLK_W-1:0]  blk_q, blk_d;
  logic              last_q, last_d;
  logic [BLK_W-1:0]  out_data_q, out_data_d;
  logic [BLK_W-1:0]  iv_eff;
  logic [SKIP_W-1:0] skip_eff;

  aes_cbc_cfg_regs #(
    .BLK_W  (BLK_W),
    .SKIP_W (SKIP_W)
  ) u_cfg_regs (
    .clk        (clk),
    .rst_n      (rst_n),
    .busy       (busy),
    .key_we     (cfg_key_we),
    .key        (cfg_key),
    .iv_we      (cfg_iv_we),
    .iv         (cfg_iv),
    .skip_we    (cfg_skip_we),
    .skip       (cfg_skip),
    .key_o      (core_key),
    .iv_eff_o   (iv_eff),
    .skip_eff_o (skip_eff),
    .cfg_err_o  (cfg_err)
  );

  always_comb begin
    state_d    = state_q;
    chain_d    = chain_q;
    skip_cnt_d = skip_cnt_q;
    blk_d      = blk_q;
    last_d     = last_q;
    out_data_d = out_data_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          chain_d    = iv_eff;
          skip_cnt_d = skip_eff;
          state_d    = S_WAIT_IN;
        end
      end
      S_WAIT_IN: begin
        if (in_valid) begin
          blk_d   = in_data ^ chain_q;
          last_d  = in_last;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (core_req_ready) state_d = S_WAIT_CORE;
      end
      S_WAIT_CORE: begin
        if (core_rsp_valid) begin
          chain_d = core_rsp_data;
          // Suppressed blocks still advance the chain.
          if (skip_cnt_q != '0) begin
            skip_cnt_d = skip_cnt_q - SKIP_W'(1);
            state_d    = last_q ? S_FIN : S_WAIT_IN;
          end else begin
            out_data_d = core_rsp_data;
            state_d    = S_EMIT;
          end
        end
      end
      S_EMIT: begin
        if (out_ready) state_d = last_q ? S_FIN : S_WAIT_IN;
      end
      S_FIN: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      chain_q    <= '0;
      skip_cnt_q <= '0;
      blk_q      <= '0;
      last_q     <= 1'b0;
      out_data_q <= '0;
    end else begin
      state_q    <= state_d;
      chain_q    <= chain_d;
      skip_cnt_q <= skip_cnt_d;
      blk_q      <= blk_d;
      last_q     <= last_d;
      out_data_q <= out_data_d;
    end
  end

  assign busy           = (state_q != S_IDLE) && (state_q != S_FIN);
  assign done           = (state_q == S_FIN);
  assign in_ready       = (state_q == S_WAIT_IN);
  assign core_req_valid = (state_q == S_ISSUE);
  assign core_block     = blk_q;
  assign out_valid      = (state_q == S_EMIT);
  assign out_data       = out_data_q;
  assign out_last       = out_valid & last_q;

endmodule

// File: tb/tb_aes_cbc_seq_ctrl.sv
// Bench for aes_cbc_seq_ctrl: AES-128 reference core model plus output scoreboard.
module tb_aes_cbc_seq_ctrl;
  import aes_cbc_pkg::*;

  localparam aes_blk_t KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam aes_blk_t IV  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam aes_blk_t P1  = 128'h6bc1bee22e409f96e93d7e117393172a;
  localparam aes_blk_t P2  = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
  localparam aes_blk_t P3  = 128'h30c81c46a35ce411e5fbc1191a0a52ef;
  localparam aes_blk_t P4  = 128'hf69f2445df4f9b17ad2b417be66c3710;
  localparam aes_blk_t C1  = 128'h7649abac8119b246cee98e9b12e9197d;
  localparam aes_blk_t C2  = 128'h5086cb9b507219ee95db113a917678b2;
  localparam aes_blk_t C3  = 128'h73bed6b8e3c1743b7116e69e22229516;
  localparam aes_blk_t C4  = 128'h3ff1caa1681fac09120eca307586e1a7;

  logic clk = 1'b0;
  logic rst_n;
  logic cfg_key_we, cfg_iv_we, cfg_skip_we, start;
  aes_blk_t cfg_key, cfg_iv;
  logic [15:0] cfg_skip;
  logic cfg_err, busy, done;
  logic in_valid, in_ready, in_last;
  aes_blk_t in_data;
  logic core_req_valid, core_req_ready, core_rsp_valid;
  aes_blk_t core_key, core_block, core_rsp_data;
  logic out_valid, out_ready, out_last;
  aes_blk_t out_data;

  aes_cbc_seq_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_key_we(cfg_key_we), .cfg_key(cfg_key),
    .cfg_iv_we(cfg_iv_we), .cfg_iv(cfg_iv),
    .cfg_skip_we(cfg_skip_we), .cfg_skip(cfg_skip),
    .cfg_err(cfg_err), .start(start), .busy(busy), .done(done),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .core_req_valid(core_req_valid), .core_req_ready(core_req_ready),
    .core_key(core_key), .core_block(core_block),
    .core_rsp_valid(core_rsp_valid), .core_rsp_data(core_rsp_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int core_fixed_lat = 0;
  logic rdy_rand = 1'b0;
  logic rdy_force = 1'b1;

  typedef struct { aes_blk_t data; logic last; } exp_t;
  exp_t exp_q[$];

  task automatic chk(input string name, input aes_blk_t act, input aes_blk_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%b required=%b", name, act, exp);
    end
  endtask

  // ---------------- AES-128 reference model ----------------
  logic [7:0] sbox [256];

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] aa = a;
    logic [7:0] bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = xt(aa);
      bb = {1'b0, bb[7:1]};
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  function automatic aes_blk_t aes_enc(input aes_blk_t key, input aes_blk_t pt);
    logic [31:0] w [44];
    logic [31:0] tmp;
    logic [7:0]  rc, a0, a1, a2, a3;
    aes_blk_t    s, t;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {sbox[tmp[23:16]], sbox[tmp[15:8]], sbox[tmp[7:0]], sbox[tmp[31:24]]} ^ {rc, 24'h0};
        rc  = xt(rc);
      end
      w[i] = w[i-4] ^ tmp;
    end
    s = pt ^ {w[0], w[1], w[2], w[3]};
    for (int r = 1; r <= 10; r++) begin
      t = '0;
      for (int c = 0; c < 4; c++)
        for (int rr = 0; rr < 4; rr++)
          t[127-8*(rr+4*c) -: 8] = sbox[s[127-8*(rr+4*((c+rr)%4)) -: 8]];
      if (r < 10) begin
        for (int c = 0; c < 4; c++) begin
          a0 = t[127-8*(4*c)   -: 8];
          a1 = t[127-8*(4*c+1) -: 8];
          a2 = t[127-8*(4*c+2) -: 8];
          a3 = t[127-8*(4*c+3) -: 8];
          s[127-8*(4*c)   -: 8] = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
          s[127-8*(4*c+1) -: 8] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
          s[127-8*(4*c+2) -: 8] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
          s[127-8*(4*c+3) -: 8] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
        end
      end else begin
        s = t;
      end
      s = s ^ {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    end
    return s;
  endfunction

  // ---------------- core model: random accept delay and latency ----------------
  initial begin
    aes_blk_t blk, key;
    int lat;
    core_req_ready = 1'b0;
    core_rsp_valid = 1'b0;
    core_rsp_data  = '0;
    forever begin
      @(negedge clk);
      if (core_req_valid) begin
        repeat ($urandom_range(0, 2)) @(negedge clk);
        blk = core_block;
        key = core_key;
        core_req_ready = 1'b1;
        @(negedge clk);
        core_req_ready = 1'b0;
        lat = (core_fixed_lat != 0) ? core_fixed_lat : int'($urandom_range(1, 20));
        repeat (lat - 1) @(negedge clk);
        core_rsp_data  = aes_enc(key, blk);
        core_rsp_valid = 1'b1;
        @(negedge clk);
        core_rsp_valid = 1'b0;
      end
    end
  end

  // out_ready changes just after the rising edge so the monitor sees it stable.
  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      out_ready = rdy_rand ? 1'($urandom_range(0, 1)) : rdy_force;
    end
  end

  // ---------------- scoreboard monitor ----------------
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (done) done_cnt++;
      if (rst_n && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk1("unexpected_beat", 1'b1, 1'b0);
        end else begin
          e = exp_q.pop_front();
          chk("out_data", out_data, e.data);
          chk1("out_last", out_last, e.last);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic start_msg(input aes_blk_t key, input aes_blk_t iv, input logic [15:0] skip);
    @(negedge clk);
    cfg_key = key;  cfg_key_we  = 1'b1;
    cfg_iv  = iv;   cfg_iv_we   = 1'b1;
    cfg_skip = skip; cfg_skip_we = 1'b1;
    start = 1'b1;
    @(negedge clk);
    cfg_key_we = 1'b0; cfg_iv_we = 1'b0; cfg_skip_we = 1'b0; start = 1'b0;
    chk1("busy_after_start", busy, 1'b1);
  endtask

  task automatic send(input aes_blk_t data, input logic last);
    bit sent = 1'b0;
    for (int i = 0; i < 500 && !sent; i++) begin
      @(negedge clk);
      if (in_ready) begin
        in_valid = 1'b1; in_data = data; in_last = last;
        @(negedge clk);
        in_valid = 1'b0;
        sent = 1'b1;
      end
    end
    if (!sent) chk1("in_ready_timeout", 1'b0, 1'b1);
  endtask

  task automatic wait_done();
    bit seen = 1'b0;
    for (int i = 0; i < 3000 && !seen; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        chk1("busy_with_done", busy, 1'b0);
      end
    end
    if (!seen) chk1("done_timeout", 1'b0, 1'b1);
  endtask

  task automatic wait_core_phase();
    bit seen_req = 1'b0;
    bit in_core = 1'b0;
    for (int i = 0; i < 500 && !in_core; i++) begin
      @(negedge clk);
      if (core_req_valid) seen_req = 1'b1;
      else if (seen_req) in_core = 1'b1;
    end
    if (!in_core) chk1("core_phase_timeout", 1'b0, 1'b1);
  endtask

  initial begin
    bit ok, seen_ov;
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv, r;
      inv = 8'h00;
      if (x != 0) begin
        r = 8'h01;
        repeat (254) r = gmul(r, 8'(x));
        inv = r;
      end
      sbox[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end

    rst_n = 1'b0;
    cfg_key_we = 1'b0; cfg_iv_we = 1'b0; cfg_skip_we = 1'b0; start = 1'b0;
    cfg_key = '0; cfg_iv = '0; cfg_skip = '0;
    in_valid = 1'b0; in_data = '0; in_last = 1'b0;
    repeat (3) @(negedge clk);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_in_ready", in_ready, 1'b0);
    chk1("rst_out_valid", out_valid, 1'b0);
    chk("rst_core_key", core_key, '0);
    chk("rst_out_data", out_data, '0);
    rst_n = 1'b1;

    // single block, skip 0
    exp_q.push_back('{C1, 1'b1});
    start_msg(KEY, IV, 16'd0);
    send(P1, 1'b1);
    wait_done();

    // two blocks, first suppressed
    exp_q.push_back('{C2, 1'b1});
    start_msg(KEY, IV, 16'd1);
    send(P1, 1'b0);
    send(P2, 1'b1);
    wait_done();

    // four blocks with random output backpressure
    rdy_rand = 1'b1;
    exp_q.push_back('{C1, 1'b0});
    exp_q.push_back('{C2, 1'b0});
    exp_q.push_back('{C3, 1'b0});
    exp_q.push_back('{C4, 1'b1});
    start_msg(KEY, IV, 16'd0);
    send(P1, 1'b0);
    send(P2, 1'b0);
    send(P3, 1'b0);
    send(P4, 1'b1);
    wait_done();
    rdy_rand = 1'b0;

    // out_ready held low for 10 cycles while a beat is presented
    rdy_force = 1'b0;
    exp_q.push_back('{C1, 1'b1});
    start_msg(KEY, IV, 16'd0);
    send(P1, 1'b1);
    seen_ov = 1'b0;
    for (int i = 0; i < 500 && !seen_ov; i++) begin
      @(negedge clk);
      if (out_valid) seen_ov = 1'b1;
    end
    chk1("stall_out_valid_seen", seen_ov, 1'b1);
    ok = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (i > 0) @(negedge clk);
      if (out_data !== C1 || in_ready !== 1'b0 || core_req_valid !== 1'b0 || out_valid !== 1'b1)
        ok = 1'b0;
    end
    chk1("stall_stable", ok, 1'b1);
    chk("stall_out_data", out_data, C1);
    rdy_force = 1'b1;
    wait_done();

    // key write while waiting on the core
    core_fixed_lat = 10;
    exp_q.push_back('{C1, 1'b1});
    start_msg(KEY, IV, 16'd0);
    send(P1, 1'b1);
    wait_core_phase();
    cfg_key = ~KEY; cfg_key_we = 1'b1;
    @(negedge clk);
    cfg_key_we = 1'b0;
    chk1("cfg_err_pulse", cfg_err, 1'b1);
    chk("core_key_locked", core_key, KEY);
    @(negedge clk);
    chk1("cfg_err_one_cycle", cfg_err, 1'b0);
    wait_done();

    // reset while waiting on the core; the late response must be ignored
    start_msg(KEY, IV, 16'd0);
    send(P1, 1'b1);
    wait_core_phase();
    rst_n = 1'b0;
    #1;
    ok = (busy === 1'b0) && (done === 1'b0) && (in_ready === 1'b0) && (core_req_valid === 1'b0) &&
         (core_key === '0) && (core_block === '0) && (out_valid === 1'b0) && (out_data === '0) &&
         (out_last === 1'b0) && (cfg_err === 1'b0);
    chk1("async_reset_outputs", ok, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    ok = 1'b1;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (busy !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b0 || core_req_valid !== 1'b0 || done !== 1'b0)
        ok = 1'b0;
    end
    chk1("late_rsp_ignored", ok, 1'b1);
    core_fixed_lat = 0;

    // skip exceeds the block count: no beats, one done
    start_msg(KEY, IV, 16'd5);
    send(P1, 1'b0);
    send(P2, 1'b0);
    send(P3, 1'b1);
    wait_done();

    repeat (5) @(negedge clk);
    chk("beats_outstanding", aes_blk_t'(exp_q.size()), '0);
    chk("done_count", aes_blk_t'(done_cnt), aes_blk_t'(6));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
